// File: rtl/mips_reg_dump.sv
// Post-halt GPR readback: walks a register range through the synchronous
// register-file read port and streams {index, data} beats over valid/ready.
module mips_reg_dump #(
    parameter int FIRST_REG = 0,
    parameter int NUM_REGS  = 32,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              cpu_halted,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    typedef enum logic [2:0] {IDLE, READ, CAPT, SEND, DONE} state_t;

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_CNT  = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] count;
    logic              go;
    logic              handshake;
    logic              cancel;

    assign go        = start && cpu_halted && !abort;
    assign handshake = out_valid && out_ready;
    assign cancel    = abort && (state != IDLE);

    always_ff @(posedge clk1) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = READ;
            READ:    state_nxt = CAPT;
            CAPT:    state_nxt = SEND;
            SEND:    if (handshake) state_nxt = out_last ? DONE : READ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort beats every other transition, including a completing handshake.
        if (cancel) state_nxt = IDLE;
    end

    always_comb begin
        busy       = (state != IDLE);
        done       = (state == DONE);
        rf_rd_en   = (state == READ);
        rf_rd_addr = (state == READ) ? idx : '0;
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            idx       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        idx   <= FIRST_IDX;
                        count <= '0;
                    end
                end
                CAPT: begin
                    out_data  <= rf_rd_data;
                    out_index <= idx;
                    out_last  <= (count == LAST_CNT);
                    out_valid <= 1'b1;
                end
                SEND: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        if (!out_last) begin
                            idx   <= idx + 1'b1;
                            count <= count + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (cancel) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mips_reg_dump.sv
// Bench for mips_reg_dump: a 6-register dump instance and a single-register
// (index 31) instance, checked by a queue scoreboard fed from the stimulus.
module tb_mips_reg_dump;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    int checks   = 0;
    int failures = 0;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic reset = 1'b1;
    logic cpu_halted = 1'b0;

    // Instance A: registers 0..5
    logic        start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b0;
    logic        busy_a, done_a, rd_en_a, valid_a, last_a;
    logic [4:0]  rd_addr_a, index_a;
    logic [31:0] rd_data_a, data_a;
    logic [31:0] regs_a [32];

    // Instance B: register 31 only
    logic        start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b0;
    logic        busy_b, done_b, rd_en_b, valid_b, last_b;
    logic [4:0]  rd_addr_b, index_b;
    logic [31:0] rd_data_b, data_b;
    logic [31:0] regs_b [32];

    mips_reg_dump #(.FIRST_REG(0), .NUM_REGS(6), .DATA_W(32), .ADDR_W(5)) dut_a (
        .clk1(clk1), .reset(reset), .cpu_halted(cpu_halted), .start(start_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .rf_rd_en(rd_en_a), .rf_rd_addr(rd_addr_a),
        .rf_rd_data(rd_data_a), .out_valid(valid_a), .out_ready(ready_a),
        .out_index(index_a), .out_data(data_a), .out_last(last_a)
    );

    mips_reg_dump #(.FIRST_REG(31), .NUM_REGS(1), .DATA_W(32), .ADDR_W(5)) dut_b (
        .clk1(clk1), .reset(reset), .cpu_halted(cpu_halted), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .rf_rd_en(rd_en_b), .rf_rd_addr(rd_addr_b),
        .rf_rd_data(rd_data_b), .out_valid(valid_b), .out_ready(ready_b),
        .out_index(index_b), .out_data(data_b), .out_last(last_b)
    );

    // Synchronous register-file read ports
    always @(posedge clk1) begin
        if (rd_en_a) rd_data_a <= regs_a[rd_addr_a];
        if (rd_en_b) rd_data_b <= regs_b[rd_addr_b];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    beat_t exp_a[$];
    beat_t exp_b[$];
    int    beats_a = 0, beats_b = 0, dones_a = 0, dones_b = 0;

    // Monitor A: pops the scoreboard on every accepted beat, checks stall stability
    logic        pv_a = 1'b0, pr_a = 1'b0, pl_a = 1'b0;
    logic [4:0]  pi_a = '0;
    logic [31:0] pd_a = '0;
    beat_t       e_a;
    always @(negedge clk1) begin
        if (reset) begin
            pv_a = 1'b0;
        end else begin
            if (valid_a) begin
                chk("a_no_read_in_send", rd_en_a, 0);
                if (pv_a && !pr_a) begin
                    chk("a_stall_index", index_a, pi_a);
                    chk("a_stall_data", data_a, pd_a);
                    chk("a_stall_last", last_a, pl_a);
                end
                if (ready_a) begin
                    if (exp_a.size() == 0) begin
                        chk("a_unexpected_beat", index_a, 6'h3f);
                    end else begin
                        e_a = exp_a.pop_front();
                        chk("a_beat_index", index_a, e_a.idx);
                        chk("a_beat_data", data_a, e_a.data);
                        chk("a_beat_last", last_a, e_a.last);
                        beats_a++;
                    end
                end
            end
            if (done_a) dones_a++;
            pv_a = valid_a; pr_a = ready_a; pi_a = index_a; pd_a = data_a; pl_a = last_a;
        end
    end

    beat_t e_b;
    always @(negedge clk1) begin
        if (!reset) begin
            if (valid_b && ready_b) begin
                if (exp_b.size() == 0) begin
                    chk("b_unexpected_beat", index_b, 6'h3f);
                end else begin
                    e_b = exp_b.pop_front();
                    chk("b_beat_index", index_b, e_b.idx);
                    chk("b_beat_data", data_b, e_b.data);
                    chk("b_beat_last", last_b, e_b.last);
                    beats_b++;
                end
            end
            if (done_b) dones_b++;
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic push_a(input int n);
        for (int k = 0; k < n; k++) begin
            exp_a.push_back('{idx: 5'(k), data: regs_a[k], last: (k == 5)});
        end
    endtask

    // Runs one full dump on instance A; returns cycles to done and to first valid
    task automatic dump_a(input bit stall, input bit poke, output int n_done, output int first_valid);
        int n = 0;
        int st = 0;
        first_valid = -1;
        n_done = -1;
        ready_a = !stall;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        while (n < 400) begin
            tick();
            n++;
            if (poke) start_a = (n >= 4 && n < 8);
            if (valid_a && first_valid < 0) first_valid = n;
            if (stall) begin
                if (valid_a && st < 5) begin ready_a = 1'b0; st++; end
                else if (valid_a) begin ready_a = 1'b1; st = 0; end
                else ready_a = 1'b0;
            end
            if (done_a) begin n_done = n; break; end
        end
        start_a = 1'b0;
    endtask

    int nd, fv, b0, d0;

    initial begin
        for (int k = 0; k < 32; k++) begin regs_a[k] = 32'(k); regs_b[k] = 32'(k); end
        // Results of the preload program: R1=10 R2=20 R3=25 R4=30 R5=55
        regs_a[1] = 32'd10; regs_a[2] = 32'd20; regs_a[3] = 32'd25;
        regs_a[4] = 32'd30; regs_a[5] = 32'd55;
        regs_b[31] = 32'hDEADBEEF;

        tick(); tick();
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_rd_en", rd_en_a, 0);
        chk("rst_rd_addr", rd_addr_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_index", index_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_last", last_a, 0);
        reset = 1'b0;
        tick();

        // Start while the CPU is still running is ignored
        start_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("gate_busy", busy_a, 0);
            chk("gate_rd_en", rd_en_a, 0);
        end
        start_a = 1'b0;
        tick();
        cpu_halted = 1'b1;

        // Happy path
        push_a(6);
        b0 = beats_a; d0 = dones_a;
        dump_a(0, 0, nd, fv);
        chk("happy_first_valid", fv, 2);
        chk("happy_done_cycle", nd, 18);
        tick();
        chk("happy_busy_fall", busy_a, 0);
        chk("happy_beats", beats_a - b0, 6);
        chk("happy_done_count", dones_a - d0, 1);
        chk("happy_queue_empty", exp_a.size(), 0);

        // Backpressure, with a start poked mid-dump
        push_a(6);
        b0 = beats_a; d0 = dones_a;
        dump_a(1, 1, nd, fv);
        chk("bp_done_seen", (nd > 0), 1);
        tick(); tick(); tick();
        chk("bp_no_restart", busy_a, 0);
        chk("bp_beats", beats_a - b0, 6);
        chk("bp_done_count", dones_a - d0, 1);
        chk("bp_queue_empty", exp_a.size(), 0);

        // Abort in the SEND of index 2, simultaneous with a handshake
        push_a(3);
        d0 = dones_a;
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (valid_a && index_a == 5'd2) break;
        end
        chk("abort_reached_idx2", valid_a && index_a == 5'd2, 1);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("abort_valid", valid_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        tick(); tick();
        chk("abort_no_done", dones_a - d0, 0);
        chk("abort_queue_empty", exp_a.size(), 0);

        // Fresh dump restarts from index 0
        push_a(6);
        b0 = beats_a;
        dump_a(0, 0, nd, fv);
        chk("restart_done_cycle", nd, 18);
        tick();
        chk("restart_beats", beats_a - b0, 6);

        // Reset in the CAPT of index 2 (out_data still holds 10)
        push_a(2);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (rd_en_a && rd_addr_a == 5'd2) break;
            tick();
        end
        tick();
        chk("capt_busy", busy_a, 1);
        chk("capt_data_before", data_a, 10);
        reset = 1'b1;
        tick();
        chk("rstmid_busy", busy_a, 0);
        chk("rstmid_done", done_a, 0);
        chk("rstmid_rd_en", rd_en_a, 0);
        chk("rstmid_rd_addr", rd_addr_a, 0);
        chk("rstmid_valid", valid_a, 0);
        chk("rstmid_index", index_a, 0);
        chk("rstmid_data", data_a, 0);
        chk("rstmid_last", last_a, 0);
        reset = 1'b0;
        tick();
        chk("rstmid_queue_empty", exp_a.size(), 0);

        // Single-register boundary on instance B
        exp_b.push_back('{idx: 5'd31, data: 32'hDEADBEEF, last: 1'b1});
        ready_b = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        nd = -1;
        for (int n = 1; n < 50; n++) begin
            tick();
            if (done_b) begin nd = n; break; end
        end
        chk("single_done_cycle", nd, 3);
        tick();
        chk("single_busy_fall", busy_b, 0);
        chk("single_beats", beats_b, 1);
        chk("single_done_count", dones_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
